// File: rtl/abl_gen.sv
// Address Bus Low generator: base + index + carry adder feeding ABL, a
// combinational carry into the ABH stage, PCL/PCC, and the page-cross fix-up FSM.
module abl_gen #(
  parameter logic [7:0] RST_VEC = 8'hFC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] base,
  input  logic [1:0] vec,
  input  logic [1:0] idx,
  input  logic       ci,
  input  logic       defer,
  input  logic       zp,
  input  logic       pc_ld,
  input  logic [7:0] DB,
  input  logic [7:0] X,
  input  logic [7:0] Y,
  output logic [7:0] ABL,
  output logic       CO,
  output logic       fix,
  output logic [7:0] PCL,
  output logic       PCC
);

  typedef enum logic {
    IDLE = 1'b0,
    FIX  = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] abl_q, abl_d;
  logic [7:0] pcl_q, pcl_d;
  logic       pcc_q, pcc_d;
  logic       co_raw;

  logic [7:0] base_val;
  logic [7:0] idx_val;
  logic [8:0] sum;
  logic [8:0] pc_inc;

  always_comb begin
    base_val = 8'h00;
    casez (base)
      3'b000:  base_val = abl_q;
      3'b001:  base_val = pcl_q;
      3'b010:  base_val = DB;
      3'b011:  base_val = 8'h00;
      3'b1??:  base_val = {5'b11111, vec, 1'b0};
      default: base_val = 8'h00;
    endcase
  end

  always_comb begin
    idx_val = 8'h00;
    case (idx)
      2'b00:   idx_val = 8'h00;
      2'b01:   idx_val = X;
      2'b10:   idx_val = Y;
      2'b11:   idx_val = 8'hFF;
      default: idx_val = 8'h00;
    endcase
  end

  assign sum    = {1'b0, base_val} + {1'b0, idx_val} + {8'd0, ci};
  assign pc_inc = {1'b0, sum[7:0]} + 9'd1;

  // A deferred carry only costs the FIX cycle when the page is really crossed;
  // during FIX the held carry is presented to ABH and every select is ignored.
  always_comb begin
    state_d = state_q;
    abl_d   = abl_q;
    pcl_d   = pcl_q;
    pcc_d   = 1'b0;
    co_raw  = 1'b0;
    case (state_q)
      IDLE: begin
        abl_d = sum[7:0];
        if (!zp) begin
          if (defer) begin
            if (sum[8]) state_d = FIX;
          end else begin
            co_raw = sum[8];
          end
        end
        if (pc_ld) {pcc_d, pcl_d} = pc_inc;
      end
      FIX: begin
        co_raw  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      abl_q   <= RST_VEC;
      pcl_q   <= 8'h00;
      pcc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      abl_q   <= abl_d;
      pcl_q   <= pcl_d;
      pcc_q   <= pcc_d;
    end
  end

  // Gating with rst_n keeps a reset taken mid-FIX from leaking a CO pulse.
  assign CO  = rst_n & co_raw;
  assign ABL = abl_q;
  assign fix = (state_q == FIX);
  assign PCL = pcl_q;
  assign PCC = pcc_q;

endmodule

// File: tb/tb_abl_gen.sv
// Scoreboard bench for abl_gen: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_abl_gen;

  logic       clk;
  logic       rst_n;
  logic [2:0] base;
  logic [1:0] vec;
  logic [1:0] idx;
  logic       ci;
  logic       defer;
  logic       zp;
  logic       pc_ld;
  logic [7:0] DB;
  logic [7:0] X;
  logic [7:0] Y;
  logic [7:0] ABL;
  logic       CO;
  logic       fix;
  logic [7:0] PCL;
  logic       PCC;

  typedef struct {
    string      name;
    logic [7:0] abl;
    logic       co;
    logic       fix;
    logic [7:0] pcl;
    logic       pcc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  abl_gen #(.RST_VEC(8'hFC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .base (base),
    .vec  (vec),
    .idx  (idx),
    .ci   (ci),
    .defer(defer),
    .zp   (zp),
    .pc_ld(pc_ld),
    .DB   (DB),
    .X    (X),
    .Y    (Y),
    .ABL  (ABL),
    .CO   (CO),
    .fix  (fix),
    .PCL  (PCL),
    .PCC  (PCC)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle's inputs just after the rising edge and queue what the
  // monitor should see at the following falling edge.
  task automatic applyStimulus(input string name, input logic r,
                               input logic [2:0] b, input logic [1:0] v,
                               input logic [1:0] ix, input logic c,
                               input logic d, input logic z, input logic pl,
                               input logic [7:0] db_v, input logic [7:0] x_v,
                               input logic [7:0] y_v,
                               input logic [7:0] e_abl, input logic e_co,
                               input logic e_fix, input logic [7:0] e_pcl,
                               input logic e_pcc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; base = b; vec = v; idx = ix; ci = c;
    defer = d; zp = z; pc_ld = pl; DB = db_v; X = x_v; Y = y_v;
    e.name = name; e.abl = e_abl; e.co = e_co; e.fix = e_fix;
    e.pcl = e_pcl; e.pcc = e_pcc;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (ABL !== e.abl) begin
      failures++;
      $display("[TB] FAIL %s.ABL got=%h exp=%h", e.name, ABL, e.abl);
    end
    checks++;
    if (CO !== e.co) begin
      failures++;
      $display("[TB] FAIL %s.CO got=%b exp=%b", e.name, CO, e.co);
    end
    checks++;
    if (fix !== e.fix) begin
      failures++;
      $display("[TB] FAIL %s.fix got=%b exp=%b", e.name, fix, e.fix);
    end
    checks++;
    if (PCL !== e.pcl) begin
      failures++;
      $display("[TB] FAIL %s.PCL got=%h exp=%h", e.name, PCL, e.pcl);
    end
    checks++;
    if (PCC !== e.pcc) begin
      failures++;
      $display("[TB] FAIL %s.PCC got=%b exp=%b", e.name, PCC, e.pcc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; base = 3'b000; vec = 2'b00; idx = 2'b00; ci = 1'b0;
    defer = 1'b0; zp = 1'b0; pc_ld = 1'b0; DB = 8'h00; X = 8'h00; Y = 8'h00;

    //            name          rst base    vec  idx  ci d  z  pl DB     X      Y      ABL    CO  fix PCL    PCC
    applyStimulus("reset_hold", 0, 3'b010, 2'd0, 2'd1, 0, 0, 0, 1, 8'hF0, 8'h20, 8'h00, 8'hFC, 0, 0, 8'h00, 0);
    applyStimulus("idle_hold",  1, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'hFC, 0, 0, 8'h00, 0);
    applyStimulus("t2_co",      1, 3'b010, 2'd0, 2'd1, 0, 0, 0, 0, 8'hF0, 8'h20, 8'h00, 8'hFC, 1, 0, 8'h00, 0);
    applyStimulus("t2_abl",     1, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 0, 0, 8'h00, 0);
    applyStimulus("t3_c1",      1, 3'b010, 2'd0, 2'd1, 0, 1, 0, 0, 8'hF0, 8'h20, 8'h00, 8'h10, 0, 0, 8'h00, 0);
    applyStimulus("t3_fix",     1, 3'b010, 2'd0, 2'd0, 0, 0, 0, 1, 8'h55, 8'h00, 8'h00, 8'h10, 1, 1, 8'h00, 0);
    applyStimulus("t3_done",    1, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 0, 0, 8'h00, 0);
    applyStimulus("t4_c1",      1, 3'b010, 2'd0, 2'd1, 0, 1, 0, 0, 8'h10, 8'h20, 8'h00, 8'h10, 0, 0, 8'h00, 0);
    applyStimulus("t4_c2",      1, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h30, 0, 0, 8'h00, 0);
    applyStimulus("t4_c3",      1, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h30, 0, 0, 8'h00, 0);
    applyStimulus("t5_zp",      1, 3'b010, 2'd0, 2'd1, 0, 1, 1, 0, 8'hF0, 8'h20, 8'h00, 8'h30, 0, 0, 8'h00, 0);
    applyStimulus("t5_wrap",    1, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 0, 0, 8'h00, 0);
    applyStimulus("t5_nofix",   1, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 0, 0, 8'h00, 0);
    applyStimulus("t6_pcld",    1, 3'b010, 2'd0, 2'd0, 0, 0, 0, 1, 8'hFF, 8'h00, 8'h00, 8'h10, 0, 0, 8'h00, 0);
    applyStimulus("t6_pcc",     1, 3'b100, 2'd3, 2'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 0, 8'h00, 1);
    applyStimulus("t6_vec",     1, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'hFE, 0, 0, 8'h00, 0);
    applyStimulus("pcl_wrap",   1, 3'b001, 2'd0, 2'd3, 1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'hFE, 1, 0, 8'h00, 0);
    applyStimulus("pcl_inc",    1, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h01, 0);
    applyStimulus("y_carry",    1, 3'b010, 2'd0, 2'd2, 0, 0, 0, 0, 8'h7F, 8'h00, 8'h81, 8'h00, 1, 0, 8'h01, 0);
    applyStimulus("y_abl",      1, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h01, 0);
    applyStimulus("b2b_c1",     1, 3'b011, 2'd0, 2'd3, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h01, 0);
    applyStimulus("b2b_fix1",   1, 3'b010, 2'd0, 2'd1, 0, 1, 0, 0, 8'hF0, 8'h20, 8'h00, 8'h00, 1, 1, 8'h01, 0);
    applyStimulus("b2b_c2",     1, 3'b010, 2'd0, 2'd1, 0, 1, 0, 0, 8'hF0, 8'h20, 8'h00, 8'h00, 0, 0, 8'h01, 0);
    applyStimulus("b2b_fix2",   1, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 1, 1, 8'h01, 0);
    applyStimulus("t1_cross",   1, 3'b010, 2'd0, 2'd1, 0, 1, 0, 0, 8'hF0, 8'h20, 8'h00, 8'h10, 0, 0, 8'h01, 0);
    applyStimulus("t1_rstfix",  0, 3'b010, 2'd0, 2'd1, 0, 1, 0, 1, 8'hF0, 8'h20, 8'h00, 8'hFC, 0, 0, 8'h00, 0);
    applyStimulus("t1_release", 1, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'hFC, 0, 0, 8'h00, 0);
    applyStimulus("t1_after",   1, 3'b000, 2'd0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'hFC, 0, 0, 8'h00, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
